alu_writeback_stage: RTL

Execute-to-writeback stage directly downstream of the 16-bit basic ALU. Captures the ALU result, destination tag and the 4-bit flag vector {OddParity, Positive, Cout, Zero}. Holds the architectural flag register, whose carry bit is fed back as the ALU carry-in. A 2-entry elastic buffer with a valid/ready handshake lets the register-file write port stall without losing results. The stage also exposes a bypass of the newest buffered result to the operand-forwarding logic.

---
 rtl/alu_writeback_stage.sv | 126 ++++++++++++
 1 files changed

// File: rtl/alu_writeback_stage.sv
// Execute-to-writeback stage behind the 16-bit ALU. It keeps the architectural flag register,
// holds results in a 2-entry elastic buffer for the register-file write port, and exposes the newest result for forwarding.
module alu_writeback_stage #(
    parameter int         DATA_W   = 16,
    parameter int         DEST_W   = 3,
    parameter logic [3:0] FLAG_RST = 4'b0101
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [3:0]        alu_flags,
    input  logic [3:0]        alu_op,
    input  logic [DEST_W-1:0] dest_in,
    input  logic              reg_we_in,
    input  logic              flag_we_in,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] wb_data,
    output logic [DEST_W-1:0] wb_dest,
    output logic              wb_we,
    output logic [3:0]        flag_reg,
    output logic              cin_out,
    output logic              fwd_valid,
    output logic [DEST_W-1:0] fwd_dest,
    output logic [DATA_W-1:0] fwd_data
);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [DEST_W-1:0] dest;
        logic              reg_we;
    } entry_t;

    localparam int FLAG_C = 1;

    entry_t     mem [2];
    logic       head;
    logic       tail;
    logic [1:0] count;
    logic [1:0] count_nxt;
    logic       in_ready_q;
    logic [3:0] flag_q;
    logic       push;
    logic       pop;
    logic       newest;

    // Only the arithmetic/shift group (INC..SUBC) produces a meaningful carry.
    function automatic logic writes_carry(input logic [3:0] op);
        return op inside {[4'h4:4'hB]};
    endfunction

    assign push = in_valid & in_ready_q & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    // NOTE: every signal assigned in always_comb gets a default first, so no path can leave it
    // unassigned and infer a latch.
    always_comb begin
        count_nxt = count;
        if (flush) begin
            count_nxt = 2'd0;
        end else if (push && !pop) begin
            count_nxt = count + 2'd1;
        end else if (pop && !push) begin
            count_nxt = count - 2'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples the
    // pre-edge value of the others regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head       <= 1'b0;
            tail       <= 1'b0;
            count      <= 2'd0;
            in_ready_q <= 1'b1;
            // NOTE: the two storage entries are reset because wb_*/fwd_* must read as zero out
            // of reset; a deep RAM would instead be left unreset and its outputs qualified.
            for (int i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
        end else begin
            count      <= count_nxt;
            in_ready_q <= (count_nxt != 2'd2);
            if (flush) begin
                head <= 1'b0;
                tail <= 1'b0;
            end else begin
                if (push) begin
                    mem[tail] <= '{data: alu_out, dest: dest_in, reg_we: reg_we_in};
                    tail      <= ~tail;
                end
                if (pop) begin
                    head <= ~head;
                end
            end
        end
    end

    // Flags commit at accept time in program order; a flushed or refused input never touches them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_q <= FLAG_RST;
        end else if (push && flag_we_in) begin
            flag_q <= alu_flags;
            if (!writes_carry(alu_op)) begin
                flag_q[FLAG_C] <= flag_q[FLAG_C];
            end
        end
    end

    assign newest    = ~tail;
    assign in_ready  = in_ready_q;
    assign out_valid = (count != 2'd0);
    assign wb_data   = mem[head].data;
    assign wb_dest   = mem[head].dest;
    assign wb_we     = out_valid & mem[head].reg_we;
    assign flag_reg  = flag_q;
    assign cin_out   = flag_q[FLAG_C];
    assign fwd_valid = out_valid & mem[newest].reg_we;
    assign fwd_dest  = mem[newest].dest;
    assign fwd_data  = mem[newest].data;

endmodule
